// File: rtl/seg7_scan_ctrl.sv
// Scan controller that multiplexes one shared BCD-to-7-segment decoder across
// NUM_DIGITS common-anode digits, with tear-free frame updates and blanking guards.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    lz_en,
    output logic [3:0]              bcd,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(NUM_DIGITS);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t                  state, state_next;
    logic                    run;
    logic [CW-1:0]           cnt, cnt_next;
    logic [DW-1:0]           dig, dig_next;
    logic                    slot_end, wrap;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_next;
    logic [4*NUM_DIGITS-1:0] active, active_next;
    logic                    pending_next;
    logic [NUM_DIGITS-1:0]   sup;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    hi_zero;

    function automatic logic [3:0] digit_sel(input logic [4*NUM_DIGITS-1:0] v,
                                             input logic [DW-1:0] idx);
        digit_sel = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (DW'(k) == idx) digit_sel = v[4*k +: 4];
        end
    endfunction

    assign seg = seg_in;

    // The first edge after reset release parks at cnt=0 so frame_start marks that cycle.
    assign slot_end = run && (cnt == CW'(REFRESH_DIV - 1));
    assign wrap     = slot_end && (dig == DW'(NUM_DIGITS - 1));

    always_comb begin
        cnt_next = cnt;
        dig_next = dig;
        if (!run) begin
            cnt_next = '0;
            dig_next = '0;
        end else if (slot_end) begin
            cnt_next = '0;
            dig_next = (dig == DW'(NUM_DIGITS - 1)) ? '0 : dig + DW'(1);
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_comb begin
        state_next = (cnt_next < CW'(BLANK_CYCLES)) ? BLANK : SHOW;
    end

    // A load landing on the wrap edge bypasses the shadow so it is not lost.
    always_comb begin
        shadow_next  = shadow;
        active_next  = active;
        pending_next = pending;
        if (load) begin
            shadow_next  = data_in;
            pending_next = 1'b1;
        end
        if (wrap) begin
            if (load)         active_next = data_in;
            else if (pending) active_next = shadow;
            pending_next = 1'b0;
        end
    end

    always_comb begin
        sup     = '0;
        hi_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (active_next[4*i +: 4] == 4'd0);
            sup[i]  = lz_en && (i != 0) && hi_zero;
        end
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state_next == SHOW && DW'(i) == dig_next && !sup[i]) an_next[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run         <= 1'b0;
            cnt         <= '0;
            dig         <= '0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            an          <= '1;
            bcd         <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            cnt         <= cnt_next;
            dig         <= dig_next;
            shadow      <= shadow_next;
            active      <= active_next;
            pending     <= pending_next;
            an          <= an_next;
            frame_start <= (cnt_next == '0) && (dig_next == '0);
            if (slot_end || !run) bcd <= digit_sel(active_next, dig_next);
        end
    end

endmodule
